gf2_divmod_ctrl: RTL
====================

GF2_DIVMOD_CTRL -- requirements
Module: gf2_divmod_ctrl

Interface
REQ-001 Parameter: N, default 32, operand width in bits; only N=32 is supported.
REQ-002 Port: clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 Port: a  input  N  dividend polynomial; bit i is the coefficient of x^i.
REQ-006 Port: b  input  N  divisor polynomial, same encoding as a.
REQ-007 Port: busy  output  1  high while in CALC.
REQ-008 Port: done  output  1  one-cycle pulse, high only in DONE.
REQ-009 Port: q  output  N  quotient register, held from DONE until the next accepted start.
REQ-010 Port: r  output  N  remainder register, held from DONE until the next accepted start.
REQ-011 Port: dz  output  1  divide-by-zero flag, valid with done and held with q and r.

Function
REQ-012 The block SHALL compute GF(2) polynomial q, r such that a = q*b XOR r (carry-less) and deg(r) < deg(b).
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 In IDLE with start=1 and b!=0, the block SHALL take one edge to load r<=a, q<=0 and an internal divisor register d<=b, clear dz and enter CALC.
REQ-015 In IDLE with start=1 and b==0, the block SHALL load r<=a and q<=0, set dz<=1 and enter DONE directly, skipping CALC.
REQ-016 start SHALL be ignored in CALC and DONE, and a and b SHALL be ignored except at the accepting edge.
REQ-017 Each CALC cycle SHALL locate the leading one of r and of d with two one-hot leading-one detectors, each built as a 16-bit upper half with priority over the 16-bit lower half.
REQ-018 Each CALC cycle SHALL encode the two one-hot results to degrees hr and hd (0..31).
REQ-019 If r!=0 and hr>=hd, the CALC cycle SHALL perform r<=r XOR (d<<(hr-hd)) and q<=q OR (1<<(hr-hd)), and remain in CALC.
REQ-020 If r==0 or hr<hd, the CALC cycle SHALL leave r and q unchanged and enter DONE.
REQ-021 The number of CALC cycles SHALL be popcount(q_final)+1, with a maximum of 33.
REQ-022 The block SHALL spend exactly one cycle in DONE with done=1 and busy=0, then return to IDLE.
REQ-023 busy and done SHALL never be high in the same cycle.
REQ-024 Shifts SHALL be performed at N bits with no bits lost, because hr-hd <= 31 and deg(d<<s) = hr.
REQ-025 The outputs q, r and dz SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-026 At any edge where reset=1, the FSM SHALL enter IDLE and q, r, busy, done and dz SHALL all become 0.
REQ-027 reset SHALL take priority over start and over any in-flight CALC or DONE.
REQ-028 After a mid-operation reset, no done pulse SHALL be produced for the aborted operation.
REQ-029 start SHALL be honoured on the first edge after reset deasserts.

Verification
REQ-030 Scenario: a=0x0000000B, b=0x00000003 -> 3 CALC cycles, then done with q=0x00000006, r=0x00000001, dz=0.
REQ-031 Scenario: a=0x00000003, b=0x00000008 -> 1 CALC cycle, then done with q=0x00000000, r=0x00000003.
REQ-032 Scenario: a=0x80000000, b=0x00000001 -> 2 CALC cycles, then done with q=0x80000000, r=0x00000000.
REQ-033 Scenario: a=0x12345678, b=0x00000000 -> next cycle done=1 with busy never high, dz=1, q=0x00000000, r=0x12345678.
REQ-034 Scenario: a=0xFFFFFFFF, b=0x00000001 with reset pulsed on the 5th CALC cycle -> IDLE, all outputs 0, no done pulse.
REQ-035 Scenario: a=0xFFFFFFFF, b=0x00000001 run to completion -> 33 CALC cycles, then q=0xFFFFFFFF, r=0x00000000.
REQ-036 Scenario: start held high across CALC and re-applied with new a and b -> the first result is unaffected; the second operation starts only from IDLE.
REQ-037 Scenario: 10^4 random a, b -> every result SHALL match a reference model of q*b XOR r == a and deg(r) < deg(b).
REQ-038 Scenario: 10^4 random a, b -> the measured CALC cycle count SHALL equal popcount(q)+1.

Source files
------------

// File: rtl/gf2_divmod_ctrl.sv
// gf2_divmod_ctrl: multi-cycle GF(2) polynomial divider producing quotient, remainder and divide-by-zero flag
module gf2_divmod_ctrl #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         dz
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state_q, state_d;
    logic [N-1:0] q_q, q_d, r_q, r_d, d_q, d_d;
    logic dz_q, dz_d;
    logic [4:0] hr, hd, sh;
    logic step;

    function automatic logic [15:0] lod16(input logic [15:0] x);
        lod16 = '0;
        for (int i = 0; i < 16; i++)
            if (x[i]) lod16 = 16'd1 << i;
    endfunction

    // upper half wins whenever it holds any one
    function automatic logic [31:0] lod32(input logic [31:0] x);
        lod32 = (x[31:16] != '0) ? {lod16(x[31:16]), 16'd0} : {16'd0, lod16(x[15:0])};
    endfunction

    function automatic logic [4:0] enc32(input logic [31:0] oh);
        enc32 = '0;
        for (int i = 0; i < 32; i++)
            if (oh[i]) enc32 = enc32 | 5'(i);
    endfunction

    always_comb begin
        hr   = enc32(lod32(r_q));
        hd   = enc32(lod32(d_q));
        sh   = hr - hd;
        step = (r_q != '0) && (hr >= hd);
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: if (start) begin
                r_d     = a;
                q_d     = '0;
                d_d     = b;
                dz_d    = (b == '0);
                state_d = (b == '0) ? DONE : CALC;
            end
            CALC: if (step) begin
                r_d = r_q ^ (d_q << sh);
                q_d = q_q | (N'(1) << sh);
            end else begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);
    assign q    = q_q;
    assign r    = r_q;
    assign dz   = dz_q;
endmodule
